// File: rtl/wb_ppm_rx.sv
// Wishbone PPM receiver: decodes an RC pulse-position train into per-channel widths in microseconds.
// Optional WB_PPM_RX_GLITCH_FILTER_EN adds a 4-sample agreement filter after the input synchronizer.
module wb_ppm_rx #(
  parameter int clk_freq   = 50000000,
  parameter int num_ch     = 8,
  parameter int sync_us    = 3000,
  parameter int timeout_ms = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        ppm_in,
  output logic        intr
);
  localparam int TickDiv = (clk_freq / 1000000 > 0) ? clk_freq / 1000000 : 1;
  localparam int PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int IdxW    = $clog2(num_ch + 1);
  localparam int MsW     = $clog2(timeout_ms + 1);
  localparam logic [15:0] SyncThr = 16'(sync_us);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t            state;
  logic [IdxW-1:0]   ch_idx;
  logic [IdxW-1:0]   count;
  logic [15:0]       shadow [num_ch];
  logic [15:0]       ch_reg [num_ch];
  logic              new_frame, frame_valid, overrun, timeout;
  logic              ctrl_enable, ctrl_irq_en, ctrl_invert;
  logic [PreW-1:0]   pre_cnt;
  logic              us_tick;
  logic [15:0]       us_cnt;
  logic [9:0]        sub_cnt;
  logic [MsW-1:0]    ms_cnt;
  logic              ms_step, is_sync;
  logic [1:0]        sync_ff;
  logic              ppm_lvl, lvl_d, rise;
  logic              bus_req, bus_wr, clr_new, clr_ovr;
  logic [3:0]        reg_sel;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:4]};

  assign bus_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign bus_wr  = bus_req & wb_we_i;
  assign reg_sel = wb_adr_i[5:2];
  assign clr_new = bus_wr && (reg_sel == 4'd0) && wb_dat_i[2];
  assign clr_ovr = bus_wr && (reg_sel == 4'd0) && wb_dat_i[3];

  always_comb begin
    rd_data = '0;
    if (reg_sel == 4'd0) begin
      rd_data = {20'd0, 4'(count), 4'd0, overrun, new_frame, timeout, frame_valid};
    end else if (reg_sel == 4'd1) begin
      rd_data = {29'd0, ctrl_invert, ctrl_irq_en, ctrl_enable};
    end else begin
      for (int k = 0; k < num_ch; k++) begin
        if (reg_sel == 4'(k + 2)) rd_data = {16'd0, ch_reg[k]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_invert <= 1'b0;
    end else begin
      wb_ack_o <= bus_req;
      wb_dat_o <= bus_req ? rd_data : 32'd0;
      if (bus_wr && reg_sel == 4'd1) begin
        ctrl_enable <= wb_dat_i[0];
        ctrl_irq_en <= wb_dat_i[1];
        ctrl_invert <= wb_dat_i[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sync_ff <= 2'b00;
    else     sync_ff <= {sync_ff[0], ppm_in};
  end

`ifdef WB_PPM_RX_GLITCH_FILTER_EN
  logic [2:0] flt_sh;
  logic       flt_lvl;

  // Level follows only after four agreeing samples: the current one plus three history bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_sh  <= 3'b000;
      flt_lvl <= 1'b0;
    end else begin
      flt_sh <= {flt_sh[1:0], sync_ff[1]};
      if (&{flt_sh, sync_ff[1]})       flt_lvl <= 1'b1;
      else if (~|{flt_sh, sync_ff[1]}) flt_lvl <= 1'b0;
    end
  end

  assign ppm_lvl = flt_lvl ^ ctrl_invert;
`else
  assign ppm_lvl = sync_ff[1] ^ ctrl_invert;
`endif

  // lvl_d tracks even while disabled so enabling never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= ppm_lvl;
  end

  assign rise    = ctrl_enable & ppm_lvl & ~lvl_d;
  assign us_tick = (pre_cnt == PreW'(TickDiv - 1));
  assign is_sync = (us_cnt >= SyncThr);
  assign ms_step = ctrl_enable && us_tick && (sub_cnt == 10'd999) && (ms_cnt != MsW'(timeout_ms));

  always_ff @(posedge clk) begin
    if (rst || us_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !ctrl_enable)               us_cnt <= 16'd0;
    else if (rise)                         us_cnt <= 16'd0;
    else if (us_tick && us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
  end

  // Frame decoder and failsafe share one block; a commit is placed after the clears so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      ch_idx      <= '0;
      count       <= '0;
      new_frame   <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      sub_cnt     <= 10'd0;
      ms_cnt      <= '0;
      for (int k = 0; k < num_ch; k++) begin
        shadow[k] <= 16'd0;
        ch_reg[k] <= 16'd0;
      end
    end else begin
      if (clr_new) new_frame <= 1'b0;
      if (clr_ovr) overrun   <= 1'b0;
      if (ctrl_enable && us_tick) sub_cnt <= (sub_cnt == 10'd999) ? 10'd0 : sub_cnt + 10'd1;
      if (ms_step) begin
        ms_cnt <= ms_cnt + 1'b1;
        if (ms_cnt == MsW'(timeout_ms - 1)) begin
          timeout     <= 1'b1;
          frame_valid <= 1'b0;
          state       <= HUNT;
        end
      end
      if (!ctrl_enable) begin
        state <= HUNT;
      end else if (rise) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              state  <= FRAME;
              ch_idx <= '0;
            end
          end
          FRAME: begin
            if (is_sync) begin
              if (ch_idx != '0) begin
                for (int k = 0; k < num_ch; k++) begin
                  if (IdxW'(k) < ch_idx) ch_reg[k] <= shadow[k];
                end
                count       <= ch_idx;
                new_frame   <= 1'b1;
                frame_valid <= 1'b1;
              end
              timeout <= 1'b0;
              ms_cnt  <= '0;
              sub_cnt <= 10'd0;
              ch_idx  <= '0;
              state   <= FRAME;
            end else if (ch_idx < IdxW'(num_ch)) begin
              for (int k = 0; k < num_ch; k++) begin
                if (ch_idx == IdxW'(k)) shadow[k] <= us_cnt;
              end
              ch_idx <= ch_idx + 1'b1;
            end else begin
              overrun <= 1'b1;
              state   <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) intr <= 1'b0;
    else     intr <= ctrl_irq_en & (new_frame | timeout);
  end
endmodule

// File: tb/tb_wb_ppm_rx.sv
// Randomized bench for wb_ppm_rx: drives PPM frames and compares the register file against a
// frame-level reference model; glitch injection is enabled when WB_PPM_RX_GLITCH_FILTER_EN is defined.
module tb_wb_ppm_rx;
  localparam int ClkFreq    = 2000000;
  localparam int Div        = ClkFreq / 1000000;
  localparam int NumCh      = 8;
  localparam int SyncUs     = 300;
  localparam int TimeoutMs  = 4;
  localparam int SyncGapUs  = 400;
  localparam int HighCycles = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wbAdr = '0;
  logic [31:0] wbDatW = '0;
  logic [31:0] wbDatR;
  logic        wbStb = 1'b0;
  logic        wbCyc = 1'b0;
  logic        wbWe = 1'b0;
  logic [3:0]  wbSel = 4'hF;
  logic        wbAck;
  logic        ppmIn = 1'b0;
  logic        intr;

  int numCompared = 0;
  int numMismatched = 0;
  int cycleCount = 0;
  int lastEdgeCycle = 0;
  int lastClearCycle = 0;
  logic polarity = 1'b0;
  logic glitchOn = 1'b0;

  logic mFrame, mNew, mValid, mOverrun, mTimeout, mHeld, mEnabled, mIrqEn;
  int   mCount;
  int   mCh [NumCh];
  int   mShadow [$];
  int   frameW [NumCh];

  wb_ppm_rx #(
    .clk_freq(ClkFreq), .num_ch(NumCh), .sync_us(SyncUs), .timeout_ms(TimeoutMs)
  ) dut (
    .clk(clock), .rst(reset),
    .wb_adr_i(wbAdr), .wb_dat_i(wbDatW), .wb_dat_o(wbDatR),
    .wb_stb_i(wbStb), .wb_cyc_i(wbCyc), .wb_we_i(wbWe), .wb_sel_i(wbSel), .wb_ack_o(wbAck),
    .ppm_in(ppmIn), .intr(intr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not complete within the cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
    int diff;
    numCompared++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h) +/-%0d", tag, observed, observed,
               expected, expected, tol);
    end
  endtask

  task automatic wbAccess(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    @(posedge clock); #1;
    wbAdr = addr; wbWe = we; wbDatW = wdata; wbStb = 1'b1; wbCyc = 1'b1;
    @(posedge clock); #1;
    checkOutput($sformatf("ack_on_%0h", addr), int'(wbAck), 1, 0);
    rdata = wbDatR;
    wbStb = 1'b0; wbCyc = 1'b0; wbWe = 1'b0;
    @(posedge clock); #1;
    checkOutput($sformatf("ack_off_%0h", addr), int'(wbAck), 0, 0);
  endtask

  task automatic wbWrite(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    wbAccess(addr, 1'b1, wdata, dummy);
  endtask

  task automatic modelReset();
    mFrame = 0; mNew = 0; mValid = 0; mOverrun = 0; mTimeout = 0; mHeld = 0;
    mEnabled = 0; mIrqEn = 0; mCount = 0;
    for (int k = 0; k < NumCh; k++) mCh[k] = 0;
    mShadow.delete();
  endtask

  task automatic modelTimeout();
    if (mEnabled && !mHeld && (cycleCount - lastClearCycle) >= TimeoutMs * 1000 * Div) begin
      mTimeout = 1; mValid = 0; mFrame = 0; mHeld = 1;
      mShadow.delete();
    end
  endtask

  task automatic modelEdge(input int gapUs);
    modelTimeout();
    if (gapUs >= SyncUs) begin
      if (mFrame) begin
        if (mShadow.size() > 0) begin
          foreach (mShadow[i]) mCh[i] = mShadow[i];
          mCount = mShadow.size();
          mNew = 1; mValid = 1;
        end
        mTimeout = 0; mHeld = 0;
        lastClearCycle = cycleCount;
      end
      mFrame = 1;
      mShadow.delete();
    end else if (mFrame) begin
      if (mShadow.size() < NumCh) mShadow.push_back(gapUs);
      else begin
        mOverrun = 1; mFrame = 0;
        mShadow.delete();
      end
    end
  endtask

  // Rising edge us microseconds after the previous one; the model sees the interval actually driven.
  task automatic applyStimulus(input int us);
    int gap;
    while (cycleCount - lastEdgeCycle < us * Div) begin
      @(posedge clock); #1;
      if (glitchOn && (cycleCount - lastEdgeCycle) == (us * Div) / 2) begin
        ppmIn = ~polarity;
        @(posedge clock); #1;
        @(posedge clock); #1;
        ppmIn = polarity;
      end
    end
    gap = cycleCount - lastEdgeCycle;
    lastEdgeCycle = cycleCount;
    ppmIn = ~polarity;
    modelEdge(gap / Div);
    repeat (HighCycles) @(posedge clock);
    #1 ppmIn = polarity;
  endtask

  task automatic sendFrame(input int n);
    for (int i = 0; i < n; i++) applyStimulus(frameW[i]);
    applyStimulus(SyncGapUs);
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic checkState(input string tag);
    logic [31:0] d;
    int expStatus;
    modelTimeout();
    expStatus = (mCount << 8) | (int'(mOverrun) << 3) | (int'(mNew) << 2) | (int'(mTimeout) << 1) | int'(mValid);
    wbAccess(32'h0, 1'b0, 32'h0, d);
    checkOutput({tag, "_status"}, int'(d), expStatus, 0);
    for (int k = 0; k < NumCh; k++) begin
      wbAccess(32'h8 + 32'(4 * k), 1'b0, 32'h0, d);
      checkOutput($sformatf("%s_ch%0d", tag, k), int'(d), mCh[k], 1);
    end
    checkOutput({tag, "_intr"}, int'(intr), int'(mIrqEn & (mNew | mTimeout)), 0);
  endtask

  task automatic clearNew();
    wbWrite(32'h0, 32'h4);
    mNew = 0;
  endtask

  task automatic randomFrame();
    int n;
    n = $urandom_range(1, NumCh);
    for (int i = 0; i < NumCh; i++) frameW[i] = $urandom_range(60, 250);
    sendFrame(n);
  endtask

  initial begin
    logic [31:0] d;
    int t0;
    modelReset();
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;

    checkState("reset");
    wbAccess(32'h4, 1'b0, 32'h0, d);
    checkOutput("reset_ctrl", int'(d), 0, 0);
    wbAccess(32'h3C, 1'b0, 32'h0, d);
    checkOutput("unmapped_rd", int'(d), 0, 0);

    wbWrite(32'h4, 32'h1);
    mEnabled = 1;
    lastEdgeCycle = cycleCount;
    lastClearCycle = cycleCount;
    applyStimulus(SyncGapUs);
    for (int i = 0; i < NumCh; i++) frameW[i] = 100 + 10 * i;
    sendFrame(NumCh);
    checkState("direct");

    wbWrite(32'h4, 32'h3);
    mIrqEn = 1;
    repeat (2) @(posedge clock);
    #1 checkOutput("irq_set", int'(intr), 1, 0);
    clearNew();
    repeat (2) @(posedge clock);
    #1 checkOutput("irq_clr", int'(intr), 0, 0);

    for (int f = 0; f < 6; f++) begin
      randomFrame();
      checkState($sformatf("rand%0d", f));
      if ($urandom_range(0, 1) == 1) clearNew();
    end

    clearNew();
    for (int i = 0; i < NumCh + 1; i++) applyStimulus(120);
    repeat (8) @(posedge clock);
    #1 checkState("overrun");
    wbWrite(32'h0, 32'h8);
    mOverrun = 0;
    applyStimulus(120);
    applyStimulus(120);
    applyStimulus(SyncGapUs);
    repeat (8) @(posedge clock);
    #1 checkState("hunt_resync");
    for (int i = 0; i < NumCh; i++) frameW[i] = $urandom_range(60, 250);
    sendFrame(4);
    checkState("post_ovr");

    while (cycleCount - lastClearCycle < 2500 * Div) @(posedge clock);
    #1 checkState("pre_timeout");
    while (cycleCount - lastClearCycle < 5500 * Div) @(posedge clock);
    #1 checkState("timeout");
    applyStimulus(SyncGapUs);
    randomFrame();
    checkState("recover");

    clearNew();
    wbWrite(32'h4, 32'h6);
    t0 = cycleCount;
    mEnabled = 0; mFrame = 0;
    mShadow.delete();
    polarity = 1'b1;
    ppmIn = 1'b1;
    repeat (6) @(posedge clock);
    #1 wbWrite(32'h4, 32'h7);
    mEnabled = 1;
    lastClearCycle = lastClearCycle + (cycleCount - t0);
    lastEdgeCycle = cycleCount;
    applyStimulus(SyncGapUs);
    for (int i = 0; i < NumCh; i++) frameW[i] = 100 + 10 * i;
    sendFrame(NumCh);
    checkState("invert");
    randomFrame();
    checkState("invert_rand");

`ifdef WB_PPM_RX_GLITCH_FILTER_EN
    glitchOn = 1'b1;
    for (int f = 0; f < 2; f++) begin
      randomFrame();
      checkState($sformatf("glitch%0d", f));
    end
    glitchOn = 1'b0;
`endif

    applyStimulus(100);
    applyStimulus(100);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    modelReset();
    checkState("midreset");
    wbAccess(32'h4, 1'b0, 32'h0, d);
    checkOutput("midreset_ctrl", int'(d), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
